if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-006 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-007 SHALL have port id_ready  input  1  decode stage accepts the IF/ID register this cycle.
REQ-008 SHALL have port imem_addr  output  32  word index to instruction memory (pc >> 2).
REQ-009 SHALL have port imem_instr  input  32  instruction word, combinational read of imem_addr.
REQ-010 SHALL have port id_valid  output  1  IF/ID register holds a valid instruction.
REQ-011 SHALL have port id_pc  output  32  byte PC of the held instruction.
REQ-012 SHALL have port id_instr  output  32  held instruction word.
REQ-013 SHALL have port halted  output  1  high while the state machine is in HALTED.
REQ-014 SHALL have port fetch_count  output  32  number of instructions loaded into IF/ID since reset.

Function
REQ-015 SHALL implement states IDLE, RUN, HALTED; HALTED is left only by rst.
REQ-016 SHALL drive imem_addr = {2'b00, pc[31:2]} combinationally in every state.
REQ-017 SHALL move IDLE->RUN on the edge where start=1; no capture occurs in IDLE, including that edge.
REQ-018 SHALL define load = RUN && !redirect_valid && (!id_valid || id_ready).
REQ-019 SHALL, on load: id_pc<=pc, id_instr<=imem_instr, id_valid<=1, fetch_count<=fetch_count+1, pc<=pc+4.
REQ-020 SHALL, in RUN with redirect_valid=1: pc<={redirect_pc[31:2],2'b00}, id_valid<=0 (flush), no capture, fetch_count unchanged; redirect has priority over stall.
REQ-021 SHALL, in RUN with id_valid=1, id_ready=0 and no redirect, hold pc, id_pc, id_instr, id_valid unchanged.
REQ-022 SHALL, when id_valid=1, id_ready=1 and no load occurs, clear id_valid.
REQ-023 SHALL, when a load captures 32'h0010_0073 (EBREAK), still present it (id_valid=1), keep pc at the EBREAK address (no +4), and enter HALTED.
REQ-024 SHALL, in HALTED, perform no loads, ignore redirect_valid and start, and drain IF/ID per REQ-022.
REQ-025 SHALL ignore redirect_valid and id_ready-based loads in IDLE (pc holds RESET_PC).
REQ-026 SHALL wrap pc modulo 2^32 (32'hFFFF_FFFC+4 -> 0) and fetch_count modulo 2^32.
REQ-027 SHALL present id_* outputs directly from registers (one-cycle latency from imem_addr to id_instr).

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set state=IDLE, pc=RESET_PC, id_valid=0, id_pc=0, id_instr=0, fetch_count=0, halted=0, overriding start, redirect_valid and any operation in progress.
REQ-029 SHALL allow rst in any state, including mid-stall and HALTED, with identical result.

Verification
REQ-030 SHALL verify free run: RESET_PC=0, start pulse, id_ready=1, imem word i = i -> id_pc 0,4,8,12 on consecutive cycles, id_instr 0,1,2,3, fetch_count 4.
REQ-031 SHALL verify stall: id_ready=0 for 3 cycles with id_pc=8 -> id_pc/id_instr/imem_addr held at 8/2/3, fetch_count unchanged; after release, next id_pc=12.
REQ-032 SHALL verify redirect during stall: id_valid=1, id_ready=0, redirect_pc=32'h0000_0042 -> next cycle id_valid=0, imem_addr=16; following cycle id_pc=32'h40.
REQ-033 SHALL verify EBREAK: word 5 = 32'h0010_0073 -> id_pc=20 valid, halted=1 next cycle, imem_addr stays 5, fetch_count=6, id_valid drops after one id_ready=1 cycle, later redirect ignored.
REQ-034 SHALL verify reset mid-run: rst asserted with id_valid=1, pc=32'h24 -> next cycle id_valid=0, imem_addr=0, fetch_count=0, halted=0, no load until start.
REQ-035 SHALL verify wrap: RESET_PC=32'hFFFF_FFF8, start, id_ready=1 -> id_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a small
// IDLE/RUN/HALTED control machine that stops fetching after an EBREAK.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        load;

  assign imem_addr   = {2'b00, pc_q[31:2]};
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_instr    = id_instr_q;
  assign fetch_count = fetch_count_q;
  assign halted      = (state_q == HALTED);

  assign load = (state_q == RUN) && !redirect_valid && (!id_valid_q || id_ready);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_instr_d    = id_instr_q;
    fetch_count_d = fetch_count_q;

    // Downstream consumed the held instruction and nothing replaces it.
    if (id_ready && !load) begin
      id_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc & 32'hFFFF_FFFC;
          id_valid_d = 1'b0;
        end else if (load) begin
          id_pc_d       = pc_q;
          id_instr_d    = imem_instr;
          id_valid_d    = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
          // EBREAK is still handed to decode, but the PC parks on it.
          if (imem_instr == EBREAK) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'd0;
      id_instr_q    <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_instr_q    <= id_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: free run, stall, redirect, EBREAK halt,
// reset mid-run and PC wrap, with hand-computed expectations.
module tb_if_stage;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        ebreak_en;

  logic [31:0] imem_addr, imem_instr, id_pc, id_instr, fetch_count;
  logic        id_valid, halted;

  logic [31:0] w_imem_addr, w_imem_instr, w_id_pc, w_id_instr, w_fetch_count;
  logic        w_id_valid, w_halted;

  int n_checks;
  int n_pass;

  // Instruction memory: word i holds i, except word 5 holds EBREAK when enabled.
  assign imem_instr   = (ebreak_en && imem_addr == 32'd5) ? EBREAK : imem_addr;
  assign w_imem_instr = w_imem_addr;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .imem_addr      (w_imem_addr),
    .imem_instr     (w_imem_instr),
    .id_valid       (w_id_valid),
    .id_pc          (w_id_pc),
    .id_instr       (w_id_instr),
    .halted         (w_halted),
    .fetch_count    (w_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("[%0t] ok   %s = %h", $time, tag, got);
    end else begin
      $display("[%0t] FAIL %s got %h expected %h", $time, tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst            = 1'b1;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_ready       = 1'b1;
    ebreak_en      = 1'b0;

    // Reset state
    do_reset();
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_instr", id_instr, 32'd0);

    // IDLE ignores redirect and does not load
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    step();
    redirect_valid = 1'b0;
    step();
    check("idle_imem_addr", imem_addr, 32'd0);
    check("idle_id_valid", {31'd0, id_valid}, 32'd0);
    check("idle_fetch_count", fetch_count, 32'd0);

    // Free run
    do_start();
    check("start_edge_no_capture", {31'd0, id_valid}, 32'd0);
    check("start_edge_count", fetch_count, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("run_id_pc_%0d", i), id_pc, 32'(4 * i));
      check($sformatf("run_id_instr_%0d", i), id_instr, 32'(i));
      check($sformatf("run_id_valid_%0d", i), {31'd0, id_valid}, 32'd1);
    end
    check("run_fetch_count", fetch_count, 32'd4);

    // Stall with id_pc = 8
    do_reset();
    do_start();
    step();
    step();
    step();
    check("pre_stall_id_pc", id_pc, 32'd8);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_id_pc_%0d", i), id_pc, 32'd8);
      check($sformatf("stall_id_instr_%0d", i), id_instr, 32'd2);
      check($sformatf("stall_imem_addr_%0d", i), imem_addr, 32'd3);
      check($sformatf("stall_count_%0d", i), fetch_count, 32'd3);
    end
    id_ready = 1'b1;
    step();
    check("release_id_pc", id_pc, 32'd12);
    check("release_count", fetch_count, 32'd4);

    // Redirect during stall
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    step();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    check("redir_id_valid", {31'd0, id_valid}, 32'd0);
    check("redir_imem_addr", imem_addr, 32'd16);
    check("redir_count", fetch_count, 32'd4);
    step();
    check("redir_id_pc", id_pc, 32'h0000_0040);
    check("redir_id_instr", id_instr, 32'd16);
    check("redir_id_valid2", {31'd0, id_valid}, 32'd1);

    // EBREAK halt
    do_reset();
    ebreak_en = 1'b1;
    do_start();
    for (int i = 0; i < 6; i++) step();
    check("ebreak_id_pc", id_pc, 32'd20);
    check("ebreak_id_instr", id_instr, EBREAK);
    check("ebreak_id_valid", {31'd0, id_valid}, 32'd1);
    check("ebreak_halted", {31'd0, halted}, 32'd1);
    check("ebreak_imem_addr", imem_addr, 32'd5);
    check("ebreak_count", fetch_count, 32'd6);
    id_ready = 1'b0;
    step();
    check("halt_hold_valid", {31'd0, id_valid}, 32'd1);
    check("halt_hold_addr", imem_addr, 32'd5);
    id_ready = 1'b1;
    step();
    check("halt_drain_valid", {31'd0, id_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    start          = 1'b1;
    step();
    step();
    redirect_valid = 1'b0;
    start          = 1'b0;
    check("halt_ignore_addr", imem_addr, 32'd5);
    check("halt_ignore_halted", {31'd0, halted}, 32'd1);
    check("halt_ignore_valid", {31'd0, id_valid}, 32'd0);
    check("halt_ignore_count", fetch_count, 32'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    check("halt_rst_addr", imem_addr, 32'd0);
    ebreak_en = 1'b0;

    // Reset mid-run
    do_start();
    for (int i = 0; i < 9; i++) step();
    check("mid_pre_addr", imem_addr, 32'd9);
    check("mid_pre_valid", {31'd0, id_valid}, 32'd1);
    rst = 1'b1;
    start = 1'b1;
    redirect_valid = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    check("mid_rst_valid", {31'd0, id_valid}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rst_count", fetch_count, 32'd0);
    check("mid_rst_halted", {31'd0, halted}, 32'd0);
    step();
    step();
    check("mid_noload_valid", {31'd0, id_valid}, 32'd0);
    check("mid_noload_count", fetch_count, 32'd0);

    // PC wrap on the second instance
    do_reset();
    check("wrap_rst_addr", w_imem_addr, 32'h3FFF_FFFE);
    do_start();
    step();
    check("wrap_id_pc_0", w_id_pc, 32'hFFFF_FFF8);
    step();
    check("wrap_id_pc_1", w_id_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_id_pc_2", w_id_pc, 32'h0000_0000);
    check("wrap_id_instr_2", w_id_instr, 32'd0);
    check("wrap_count", w_fetch_count, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
